// File: rtl/cook_timer_controller.sv
// Microwave cook timer: BCD keypad entry, one-second countdown, pause/resume
// with door interlock, and a timed end-of-cook beep.
module cook_timer_controller #(
  parameter int unsigned TICK_DIV    = 100,
  parameter int unsigned DONE_CYCLES = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        start,
  input  logic        stop_clear,
  input  logic        door_open,
  output logic        mag_on,
  output logic [15:0] time_bcd,
  output logic [1:0]  state,
  output logic        done_beep,
  output logic        key_err
);

  localparam int unsigned TIME_W = 16;
  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned DONE_W = $clog2(DONE_CYCLES + 1);

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [DONE_W-1:0] DONE_LAST  = DONE_W'(DONE_CYCLES - 1);
  localparam logic [TIME_W-1:0] QUICK_TIME = 16'h0030;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COOK  = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [DONE_W-1:0] done_cnt_q, done_cnt_d;
  logic              done_beep_q;
  logic              key_err_q;

  logic              start_ok_c;
  logic              key_ok_c;
  logic              key_digit_c;
  logic              key_bad_c;
  logic [TIME_W-1:0] time_dec_c;

  // One-second BCD decrement; seconds tens above 5 are counted down as entered.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] m_t, m_u, s_t, s_u;
    {m_t, m_u, s_t, s_u} = t;
    if (s_u != 4'd0) begin
      s_u = s_u - 4'd1;
    end else if (s_t != 4'd0) begin
      s_t = s_t - 4'd1;
      s_u = 4'd9;
    end else begin
      if (m_u != 4'd0) begin
        m_u = m_u - 4'd1;
      end else begin
        m_t = m_t - 4'd1;
        m_u = 4'd9;
      end
      s_t = 4'd5;
      s_u = 4'd9;
    end
    return {m_t, m_u, s_t, s_u};
  endfunction

  // Input qualification: keys only count when no higher-priority input is active.
  always_comb begin
    start_ok_c  = start && !door_open;
    key_ok_c    = key_valid && !stop_clear && !door_open && !start;
    key_digit_c = key_ok_c && (key_code <= 4'd9);
    key_bad_c   = key_ok_c && (key_code > 4'd9);
    time_dec_c  = bcd_dec(time_q);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      time_q      <= '0;
      tick_q      <= '0;
      done_cnt_q  <= '0;
      done_beep_q <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_q      <= time_d;
      tick_q      <= tick_d;
      done_cnt_q  <= done_cnt_d;
      done_beep_q <= (state_d == S_DONE);
      key_err_q   <= key_bad_c;
    end
  end

  // Next-state, time, tick and done-counter logic in priority order.
  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    tick_d     = tick_q;
    done_cnt_d = done_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (stop_clear) begin
          time_d = '0;
        end else if (start_ok_c) begin
          state_d = S_COOK;
          tick_d  = '0;
          if (time_q == '0) begin
            time_d = QUICK_TIME;
          end
        end else if (key_digit_c) begin
          time_d = {time_q[11:0], key_code};
        end
      end
      S_COOK: begin
        if (stop_clear || door_open) begin
          state_d = S_PAUSE;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          time_d = time_dec_c;
          if (time_dec_c == '0) begin
            state_d    = S_DONE;
            done_cnt_d = '0;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_PAUSE: begin
        if (stop_clear) begin
          state_d = S_IDLE;
          time_d  = '0;
        end else if (start_ok_c) begin
          state_d = S_COOK;
        end
      end
      S_DONE: begin
        if (stop_clear || door_open) begin
          state_d = S_IDLE;
        end else if (done_cnt_q == DONE_LAST) begin
          state_d = S_IDLE;
        end else begin
          done_cnt_d = done_cnt_q + DONE_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Magnetron drops in the same cycle the door opens.
  always_comb begin
    mag_on = (state_q == S_COOK) && !door_open;
  end

  assign time_bcd  = time_q;
  assign state     = state_q;
  assign done_beep = done_beep_q;
  assign key_err   = key_err_q;

endmodule

// File: tb/tb_cook_timer_controller.sv
// Bench for cook_timer_controller: decimal-number reference model, per-cycle
// comparison, directed literal pins and randomized cook episodes.
module tb_cook_timer_controller;

  localparam int unsigned TICK_DIV    = 4;
  localparam int unsigned DONE_CYCLES = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        start;
  logic        stop_clear;
  logic        door_open;
  logic        mag_on;
  logic [15:0] time_bcd;
  logic [1:0]  state;
  logic        done_beep;
  logic        key_err;

  cook_timer_controller #(
    .TICK_DIV    (TICK_DIV),
    .DONE_CYCLES (DONE_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .start      (start),
    .stop_clear (stop_clear),
    .door_open  (door_open),
    .mag_on     (mag_on),
    .time_bcd   (time_bcd),
    .state      (state),
    .done_beep  (done_beep),
    .key_err    (key_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: time held as a plain 4-digit decimal number mmss.
  int m_st = 0;
  int m_n = 0;
  int m_ph = 0;
  int m_dleft = 0;
  bit m_beep = 1'b0;
  bit m_kerr = 1'b0;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic pin(input string nm, input logic [15:0] dut_v, input logic [15:0] mdl_v,
                     input logic [15:0] exp);
    cmp({nm, " dut"}, dut_v, exp);
    cmp({nm, " model"}, mdl_v, exp);
  endtask

  // Reference model stepped on every rising edge from the applied inputs.
  always @(posedge clk) begin : model
    bit kok;
    kok = key_valid && !stop_clear && !door_open && !start;
    if (!rst_n) begin
      m_st = 0; m_n = 0; m_ph = 0; m_dleft = 0; m_kerr = 1'b0;
    end else begin
      m_kerr = kok && (key_code > 4'd9);
      case (m_st)
        0: begin
          if (stop_clear) m_n = 0;
          else if (start && !door_open) begin
            if (m_n == 0) m_n = 30;
            m_ph = 0;
            m_st = 1;
          end else if (kok && key_code <= 4'd9) begin
            m_n = (m_n * 10 + int'(key_code)) % 10000;
          end
        end
        1: begin
          if (stop_clear || door_open) m_st = 2;
          else begin
            m_ph++;
            if (m_ph == int'(TICK_DIV)) begin
              m_ph = 0;
              if (m_n % 100 != 0) m_n = m_n - 1;
              else m_n = (m_n / 100 - 1) * 100 + 59;
              if (m_n == 0) begin
                m_st = 3;
                m_dleft = int'(DONE_CYCLES);
              end
            end
          end
        end
        2: begin
          if (stop_clear) begin
            m_n = 0;
            m_st = 0;
          end else if (start && !door_open) m_st = 1;
        end
        default: begin
          if (stop_clear || door_open) m_st = 0;
          else begin
            m_dleft--;
            if (m_dleft == 0) m_st = 0;
          end
        end
      endcase
    end
    m_beep = (m_st == 3);
  end

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #5;
    if (chk_en) begin
      cmp("state", 16'(state), 16'(m_st));
      cmp("time_bcd", time_bcd, to_bcd(m_n));
      cmp("done_beep", 16'(done_beep), 16'(m_beep));
      cmp("key_err", 16'(key_err), 16'(m_kerr));
      cmp("mag_on", 16'(mag_on), 16'((m_st == 1) && !door_open));
    end
  end

  task automatic set_in(input bit sc, input bit door, input bit st, input bit kv,
                        input logic [3:0] kc);
    stop_clear = sc;
    door_open  = door;
    start      = st;
    key_valid  = kv;
    key_code   = kc;
  endtask

  task automatic edge1();
    @(posedge clk);
    #2;
  endtask

  task automatic edges(input int n);
    repeat (n) edge1();
  endtask

  task automatic key(input logic [3:0] k);
    set_in(1'b0, 1'b0, 1'b0, 1'b1, k);
    edge1();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic press_start();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    edge1();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    edge1();
    chk_en = 1'b1;
    edge1();
    pin("reset state", 16'(state), 16'(m_st), 16'd0);
    pin("reset time", time_bcd, to_bcd(m_n), 16'h0000);
    pin("reset mag_on", 16'(mag_on), 16'((m_st == 1) && !door_open), 16'd0);
    rst_n = 1'b1;

    // Keypad entry and invalid key
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    pin("entry 12345", time_bcd, to_bcd(m_n), 16'h2345);
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 4'hA);
    edge1();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    pin("key_err pulse", 16'(key_err), 16'(m_kerr), 16'd1);
    pin("bad key keeps time", time_bcd, to_bcd(m_n), 16'h2345);
    edge1();
    pin("key_err drop", 16'(key_err), 16'(m_kerr), 16'd0);

    // Countdown across a minute boundary
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    edge1();
    key(4'd1); key(4'd0); key(4'd1);
    pin("entry 0101", time_bcd, to_bcd(m_n), 16'h0101);
    press_start();
    pin("cook state", 16'(state), 16'(m_st), 16'd1);
    pin("cook mag_on", 16'(mag_on), 16'((m_st == 1) && !door_open), 16'd1);
    edges(4);
    pin("after 4 cycles", time_bcd, to_bcd(m_n), 16'h0100);
    edges(4);
    pin("after 8 cycles", time_bcd, to_bcd(m_n), 16'h0059);

    // Two clears: COOK -> PAUSE -> IDLE
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    edge1();
    pin("clear pauses", 16'(state), 16'(m_st), 16'd2);
    edge1();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    pin("clear idles", 16'(state), 16'(m_st), 16'd0);
    pin("clear zeroes", time_bcd, to_bcd(m_n), 16'h0000);

    // Completion and beep duration
    key(4'd2);
    press_start();
    edges(7);
    pin("pre-done time", time_bcd, to_bcd(m_n), 16'h0001);
    pin("pre-done state", 16'(state), 16'(m_st), 16'd1);
    edge1();
    pin("done state", 16'(state), 16'(m_st), 16'd3);
    pin("done time", time_bcd, to_bcd(m_n), 16'h0000);
    pin("done beep", 16'(done_beep), 16'(m_beep), 16'd1);
    edges(2);
    pin("done 3rd cycle", 16'(state), 16'(m_st), 16'd3);
    edge1();
    pin("done to idle", 16'(state), 16'(m_st), 16'd0);
    pin("beep off", 16'(done_beep), 16'(m_beep), 16'd0);

    // Door interlock and resume with preserved tick phase
    key(4'd5);
    press_start();
    edges(2);
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    #1;
    pin("mag off same cycle", 16'(mag_on), 16'((m_st == 1) && !door_open), 16'd0);
    edge1();
    pin("door pauses", 16'(state), 16'(m_st), 16'd2);
    pin("pause keeps time", time_bcd, to_bcd(m_n), 16'h0005);
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    edge1();
    pin("start ignored door open", 16'(state), 16'(m_st), 16'd2);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    edge1();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    pin("resume cook", 16'(state), 16'(m_st), 16'd1);
    pin("resume time", time_bcd, to_bcd(m_n), 16'h0005);
    edge1();
    pin("phase kept 1", time_bcd, to_bcd(m_n), 16'h0005);
    edge1();
    pin("phase kept 2", time_bcd, to_bcd(m_n), 16'h0004);

    // Quick start then clear twice
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    edges(2);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    press_start();
    pin("quick start time", time_bcd, to_bcd(m_n), 16'h0030);
    pin("quick start state", 16'(state), 16'(m_st), 16'd1);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    edge1();
    pin("quick clear pause", 16'(state), 16'(m_st), 16'd2);
    edge1();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    pin("quick clear idle", 16'(state), 16'(m_st), 16'd0);
    pin("quick clear time", time_bcd, to_bcd(m_n), 16'h0000);

    // Unnormalised seconds: 0090 -> 0089
    key(4'd9); key(4'd0);
    press_start();
    edges(4);
    pin("0090 step", time_bcd, to_bcd(m_n), 16'h0089);

    // Reset mid-cook
    rst_n = 1'b0;
    edge1();
    rst_n = 1'b1;
    pin("reset cook state", 16'(state), 16'(m_st), 16'd0);
    pin("reset cook time", time_bcd, to_bcd(m_n), 16'h0000);
    pin("reset cook mag", 16'(mag_on), 16'((m_st == 1) && !door_open), 16'd0);

    // Randomized cook episodes
    for (int ep = 0; ep < 70; ep++) begin
      int nd;
      int len;
      int door_cnt;
      int r;
      bit sc;
      bit door;
      bit st;
      bit kv;
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      edges(2);
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      nd = int'($urandom_range(1, 2));
      for (int i = 0; i < nd; i++) begin
        if ($urandom_range(0, 3) == 0) key(4'($urandom_range(0, 15)));
        else key(4'($urandom_range(0, 9)));
      end
      press_start();
      len = int'($urandom_range(100, 450));
      door_cnt = 0;
      for (int c = 0; c < len; c++) begin
        r = int'($urandom_range(0, 99));
        sc = (r < 2);
        if (door_cnt > 0) begin
          door_cnt--;
          door = 1'b1;
        end else if (r >= 2 && r < 5) begin
          door_cnt = int'($urandom_range(0, 4));
          door = 1'b1;
        end else begin
          door = 1'b0;
        end
        st = ($urandom_range(0, 3) == 0);
        kv = !sc && !door && !st && ($urandom_range(0, 7) == 0);
        rst_n = ($urandom_range(0, 599) != 0);
        set_in(sc, door, st, kv, 4'($urandom_range(0, 15)));
        edge1();
      end
      rst_n = 1'b1;
    end

    set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    edge1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
